parallax_scene_sequencer: RTL and testbench

//   Frame-level scheduler for the parallax background layers (star fields, mountain bands).

---
 rtl/parallax_scene_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_parallax_scene_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parallax_scene_sequencer.sv
// Frame-level scene scheduler for the parallax background layers.
// Steps IDLE -> RESEED -> FADE_IN -> RUN -> FADE_OUT once per frame_start,
// producing per-layer scroll offsets, layer enables, reseed strobes,
// a global brightness and a scene counter. Layer speeds are written
// through a valid/ready port that is closed only on frame_start cycles.
module parallax_scene_sequencer #(
    parameter int NUM_LAYERS   = 3,
    parameter int OFS_W        = 10,
    parameter int SCENE_FRAMES = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_start,
    input  logic                        run,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [1:0]                  cfg_layer,
    input  logic [3:0]                  cfg_speed,
    output logic [NUM_LAYERS*OFS_W-1:0] layer_ofs,
    output logic [NUM_LAYERS-1:0]       layer_en,
    output logic [NUM_LAYERS-1:0]       reseed,
    output logic [2:0]                  brightness,
    output logic [3:0]                  scene,
    output logic                        busy
);

    localparam int CNT_W = $clog2(SCENE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCENE_FRAMES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RESEED   = 3'd1,
        ST_FADE_IN  = 3'd2,
        ST_RUN      = 3'd3,
        ST_FADE_OUT = 3'd4
    } state_t;

    state_t                  state_r, state_nx_s;
    logic [2:0]              bri_r, bri_nx_s;
    logic [3:0]              scene_r;
    logic [CNT_W-1:0]        cnt_r, cnt_nx_s;
    logic [OFS_W-1:0]        ofs_r   [NUM_LAYERS];
    logic [3:0]              speed_r [NUM_LAYERS];
    logic [NUM_LAYERS-1:0]   reseed_r, en_r;
    logic                    busy_r;
    logic                    adv_s, enter_s, cfg_we_s;

    // Signed 4-bit speed widened to offset width, so the add wraps mod 2^OFS_W.
    function automatic logic [OFS_W-1:0] sext_speed(input logic [3:0] s);
        return OFS_W'($signed(s));
    endfunction

    // Speeds may change on any cycle that is not a frame update cycle.
    assign cfg_ready = ~frame_start;
    assign cfg_we_s  = cfg_valid & cfg_ready;

    // Next-state, brightness and frame-counter logic, evaluated per frame_start.
    always_comb begin
        state_nx_s = state_r;
        bri_nx_s   = bri_r;
        cnt_nx_s   = cnt_r;
        adv_s      = 1'b0;
        enter_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_start && run) begin
                    state_nx_s = ST_RESEED;
                    enter_s    = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RESEED: begin
                state_nx_s = ST_FADE_IN;
            end
            ST_FADE_IN: begin
                if (frame_start) begin
                    adv_s = 1'b1;
                    if (!run) begin
                        state_nx_s = ST_FADE_OUT;
                    end else if (bri_r == 3'd7) begin
                        state_nx_s = ST_RUN;
                    end else begin
                        bri_nx_s = bri_r + 3'd1;
                    end
                end else begin
                    state_nx_s = ST_FADE_IN;
                end
            end
            ST_RUN: begin
                if (frame_start) begin
                    adv_s = 1'b1;
                    if ((cnt_r == CNT_LAST) || !run) begin
                        state_nx_s = ST_FADE_OUT;
                        cnt_nx_s   = '0;
                    end else begin
                        cnt_nx_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_FADE_OUT: begin
                if (frame_start) begin
                    adv_s = 1'b1;
                    if (bri_r == 3'd0) begin
                        if (run) begin
                            state_nx_s = ST_RESEED;
                            enter_s    = 1'b1;
                        end else begin
                            state_nx_s = ST_IDLE;
                        end
                    end else begin
                        bri_nx_s = bri_r - 3'd1;
                    end
                end else begin
                    state_nx_s = ST_FADE_OUT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
        if (enter_s) begin
            cnt_nx_s = '0;
        end else begin
            cnt_nx_s = cnt_nx_s;
        end
    end

    // Control registers and registered status outputs, derived from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            bri_r    <= 3'd0;
            scene_r  <= 4'd0;
            cnt_r    <= '0;
            reseed_r <= '0;
            en_r     <= '0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            bri_r    <= bri_nx_s;
            cnt_r    <= cnt_nx_s;
            scene_r  <= enter_s ? (scene_r + 4'd1) : scene_r;
            reseed_r <= (state_nx_s == ST_RESEED) ? '1 : '0;
            en_r     <= ((state_nx_s == ST_FADE_IN) || (state_nx_s == ST_RUN) ||
                         (state_nx_s == ST_FADE_OUT)) ? '1 : '0;
            busy_r   <= (state_nx_s != ST_IDLE);
        end
    end

    // Per-layer offsets and speed table; a scene entry zeroes offsets over any advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                ofs_r[i]   <= '0;
                speed_r[i] <= 4'(i + 1);
            end
        end else begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (enter_s) begin
                    ofs_r[i] <= '0;
                end else if (adv_s) begin
                    ofs_r[i] <= ofs_r[i] + sext_speed(speed_r[i]);
                end else begin
                    ofs_r[i] <= ofs_r[i];
                end
                if (cfg_we_s && (cfg_layer == 2'(i))) begin
                    speed_r[i] <= cfg_speed;
                end else begin
                    speed_r[i] <= speed_r[i];
                end
            end
        end
    end

    // Pack the offset array onto the flat output bus.
    always_comb begin
        layer_ofs = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            layer_ofs[i*OFS_W +: OFS_W] = ofs_r[i];
        end
    end

    assign layer_en   = en_r;
    assign reseed     = reseed_r;
    assign brightness = bri_r;
    assign scene      = scene_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_parallax_scene_sequencer.sv
// Self-checking bench for parallax_scene_sequencer: directed scenarios plus a
// randomized run, all checked against a frame-rule reference model.
module tb_parallax_scene_sequencer;

    localparam int NL = 3;
    localparam int OW = 10;
    localparam int SF = 4;
    localparam int VW = NL*OW + 2*NL + 8;
    localparam int P_IDLE = 0, P_RESEED = 1, P_FI = 2, P_RUN = 3, P_FO = 4;

    logic clk = 1'b0;
    logic reset, frame_start, run, cfg_valid;
    logic [1:0] cfg_layer;
    logic [3:0] cfg_speed;
    logic cfg_ready;
    logic [NL*OW-1:0] layer_ofs;
    logic [NL-1:0] layer_en, reseed;
    logic [2:0] brightness;
    logic [3:0] scene;
    logic busy;
    logic [VW-1:0] obs_vec;

    int tests = 0;
    int fails = 0;
    logic obs_ready;

    int m_phase, m_bri, m_scene, m_cnt;
    int m_ofs [NL];
    int m_spd [NL];

    parallax_scene_sequencer #(.NUM_LAYERS(NL), .OFS_W(OW), .SCENE_FRAMES(SF)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .run(run),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_layer(cfg_layer),
        .cfg_speed(cfg_speed), .layer_ofs(layer_ofs), .layer_en(layer_en),
        .reseed(reseed), .brightness(brightness), .scene(scene), .busy(busy)
    );

    always #5 clk = ~clk;

    assign obs_vec = {layer_ofs, layer_en, reseed, brightness, scene, busy};

    function automatic int sval(input int s);
        return (s >= 8) ? s - 16 : s;
    endfunction

    // Reference model: one clock edge with the given inputs.
    task automatic model_step(input bit rst, input bit fs, input bit rn,
                              input bit cv, input int cl, input int cs);
        bit adv, enter;
        adv = 0;
        enter = 0;
        if (!rst) begin
            m_phase = P_IDLE; m_bri = 0; m_scene = 0; m_cnt = 0;
            for (int i = 0; i < NL; i++) begin
                m_ofs[i] = 0;
                m_spd[i] = i + 1;
            end
            return;
        end
        case (m_phase)
            P_IDLE:   if (fs && rn) enter = 1;
            P_RESEED: m_phase = P_FI;
            P_FI: if (fs) begin
                adv = 1;
                if (!rn) m_phase = P_FO;
                else if (m_bri == 7) m_phase = P_RUN;
                else m_bri++;
            end
            P_RUN: if (fs) begin
                adv = 1;
                if (m_cnt == SF - 1 || !rn) begin
                    m_phase = P_FO;
                    m_cnt = 0;
                end else m_cnt++;
            end
            P_FO: if (fs) begin
                adv = 1;
                if (m_bri == 0) begin
                    if (rn) enter = 1;
                    else m_phase = P_IDLE;
                end else m_bri--;
            end
            default: m_phase = P_IDLE;
        endcase
        if (adv)
            for (int i = 0; i < NL; i++)
                m_ofs[i] = (m_ofs[i] + sval(m_spd[i])) & ((1 << OW) - 1);
        if (enter) begin
            m_scene = (m_scene + 1) % 16;
            m_cnt = 0;
            m_phase = P_RESEED;
            for (int i = 0; i < NL; i++) m_ofs[i] = 0;
        end
        if (cv && !fs && cl < NL) m_spd[cl] = cs;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [NL*OW-1:0] o;
        logic [NL-1:0] en, rs;
        logic [2:0] b;
        logic [3:0] sc;
        logic bz;
        for (int i = 0; i < NL; i++) o[i*OW +: OW] = OW'(m_ofs[i]);
        en = (m_phase == P_FI || m_phase == P_RUN || m_phase == P_FO) ? '1 : '0;
        rs = (m_phase == P_RESEED) ? '1 : '0;
        b  = 3'(m_bri);
        sc = 4'(m_scene);
        bz = (m_phase != P_IDLE);
        return {o, en, rs, b, sc, bz};
    endfunction

    // Drive one cycle of inputs, clock it into DUT and model, settle past the edge.
    task automatic tick(input bit fs, input bit rn, input bit cv, input int cl, input int cs);
        frame_start = fs; run = rn; cfg_valid = cv;
        cfg_layer = 2'(cl); cfg_speed = 4'(cs);
        #1 obs_ready = cfg_ready;
        @(posedge clk);
        model_step(reset, fs, rn, cv, cl, cs);
        #1;
        frame_start = 1'b0; cfg_valid = 1'b0;
    endtask

    task automatic frame(input bit rn, input int gap);
        tick(1'b1, rn, 1'b0, 0, 0);
        repeat (gap) tick(1'b0, rn, 1'b0, 0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(1'b0, 1'b1, 1'b0, 0, 0);
        tick(1'b0, 1'b1, 1'b0, 0, 0);
        tests++;
        if (obs_vec !== {VW{1'b0}}) begin
            fails++; $display("FAIL reset_outputs got %h want 0", obs_vec);
        end
        tests++;
        if (obs_ready !== 1'b1) begin
            fails++; $display("FAIL reset_cfg_ready got %b want 1", obs_ready);
        end
        reset = 1'b1;
    endtask

    task automatic test_fade_in();
        tick(1'b1, 1'b1, 1'b0, 0, 0);
        tests++;
        if (reseed !== 3'b111 || scene !== 4'd1) begin
            fails++; $display("FAIL reseed_strobe got reseed=%b scene=%0d want 111/1", reseed, scene);
        end
        tick(1'b0, 1'b1, 1'b0, 0, 0);
        tests++;
        if (reseed !== 3'b000 || obs_vec !== exp_vec()) begin
            fails++; $display("FAIL reseed_one_cycle got %h want %h", obs_vec, exp_vec());
        end
        repeat (14) tick(1'b0, 1'b1, 1'b0, 0, 0);
        for (int k = 2; k <= 8; k++) begin
            tick(1'b1, 1'b1, 1'b0, 0, 0);
            tests++;
            if (brightness !== 3'(k - 1) || obs_vec !== exp_vec()) begin
                fails++; $display("FAIL fade_in_pulse%0d got bri=%0d want %0d", k, brightness, k - 1);
            end
            repeat (15) tick(1'b0, 1'b1, 1'b0, 0, 0);
        end
        tick(1'b1, 1'b1, 1'b0, 0, 0);
        tests++;
        if (layer_ofs !== {10'd24, 10'd16, 10'd8} || brightness !== 3'd7 || obs_vec !== exp_vec()) begin
            fails++; $display("FAIL enter_run_offsets got %h want 24/16/8", layer_ofs);
        end
        repeat (3) tick(1'b0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_speed_wrap();
        reset = 1'b0;
        tick(1'b0, 1'b1, 1'b0, 0, 0);
        reset = 1'b1;
        frame(1'b1, 3);
        frame(1'b1, 3);
        tests++;
        if (layer_ofs[OW-1:0] !== 10'd1) begin
            fails++; $display("FAIL wrap_setup got ofs0=%0d want 1", layer_ofs[OW-1:0]);
        end
        tick(1'b0, 1'b1, 1'b1, 0, 15);
        frame(1'b1, 3);
        tests++;
        if (layer_ofs !== {10'd6, 10'd4, 10'd0} || obs_vec !== exp_vec()) begin
            fails++; $display("FAIL neg_speed_step got %h want 6/4/0", layer_ofs);
        end
        frame(1'b1, 3);
        tests++;
        if (layer_ofs !== {10'd9, 10'd6, 10'd1023} || obs_vec !== exp_vec()) begin
            fails++; $display("FAIL neg_speed_wrap got %h want 9/6/1023", layer_ofs);
        end
    endtask

    task automatic test_cfg_hold();
        tick(1'b1, 1'b1, 1'b1, 1, 5);
        tests++;
        if (obs_ready !== 1'b0) begin
            fails++; $display("FAIL ready_on_frame got %b want 0", obs_ready);
        end
        tests++;
        if (layer_ofs[OW +: OW] !== 10'd8 || obs_vec !== exp_vec()) begin
            fails++; $display("FAIL old_speed_on_frame got ofs1=%0d want 8", layer_ofs[OW +: OW]);
        end
        tick(1'b0, 1'b1, 1'b1, 1, 5);
        tests++;
        if (obs_ready !== 1'b1) begin
            fails++; $display("FAIL ready_after_frame got %b want 1", obs_ready);
        end
        tick(1'b0, 1'b1, 1'b0, 0, 0);
        frame(1'b1, 2);
        tests++;
        if (layer_ofs[OW +: OW] !== 10'd13 || obs_vec !== exp_vec()) begin
            fails++; $display("FAIL new_speed_applied got ofs1=%0d want 13", layer_ofs[OW +: OW]);
        end
    endtask

    task automatic test_scene_cycle();
        bit wrapped = 0, have_prev = 0;
        int pulses = 0;
        for (int f = 0; f < 1000 && !wrapped; f++) begin
            tick(1'b1, 1'b1, 1'b0, 0, 0);
            pulses++;
            tests++;
            if (obs_vec !== exp_vec()) begin
                fails++; $display("FAIL scene_frame%0d got %h want %h", f, obs_vec, exp_vec());
            end
            if (reseed === 3'b111) begin
                if (have_prev) begin
                    tests++;
                    if (pulses != 20) begin
                        fails++; $display("FAIL scene_length got %0d pulses want 20", pulses);
                    end
                end
                have_prev = 1;
                pulses = 0;
                if (scene === 4'd0) wrapped = 1;
            end
            tick(1'b0, 1'b1, 1'b0, 0, 0);
            tick(1'b0, 1'b1, 1'b0, 0, 0);
        end
        tests++;
        if (!wrapped || m_scene != 0) begin
            fails++; $display("FAIL scene_wrap got scene=%0d want 0 after 15", scene);
        end
    endtask

    task automatic test_run_drop();
        int n = 0;
        int snap [NL];
        for (int f = 0; f < 50 && m_phase != P_RUN; f++) frame(1'b1, 2);
        tests++;
        if (m_phase != P_RUN || brightness !== 3'd7) begin
            fails++; $display("FAIL reach_run got bri=%0d want 7", brightness);
        end
        while (busy === 1'b1 && n < 30) begin
            frame(1'b0, 2);
            n++;
            tests++;
            if (obs_vec !== exp_vec()) begin
                fails++; $display("FAIL wind_down%0d got %h want %h", n, obs_vec, exp_vec());
            end
        end
        tests++;
        if (n != 9 || layer_en !== 3'b000 || busy !== 1'b0) begin
            fails++; $display("FAIL idle_after_drop got pulses=%0d en=%b busy=%b want 9/000/0", n, layer_en, busy);
        end
        for (int i = 0; i < NL; i++) snap[i] = m_ofs[i];
        repeat (3) frame(1'b0, 2);
        tests++;
        if (layer_ofs !== {OW'(snap[2]), OW'(snap[1]), OW'(snap[0])}) begin
            fails++; $display("FAIL idle_frozen got %h want %0d/%0d/%0d", layer_ofs, snap[2], snap[1], snap[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        for (int f = 0; f < 50 && m_phase != P_RUN; f++) frame(1'b1, 2);
        tick(1'b0, 1'b1, 1'b0, 0, 0);
        reset = 1'b0;
        tick(1'b1, 1'b1, 1'b1, 0, 7);
        reset = 1'b1;
        tests++;
        if (obs_vec !== {VW{1'b0}}) begin
            fails++; $display("FAIL mid_run_reset got %h want 0", obs_vec);
        end
        tick(1'b0, 1'b1, 1'b0, 0, 0);
        tests++;
        if (obs_ready !== 1'b1) begin
            fails++; $display("FAIL mid_run_reset_ready got %b want 1", obs_ready);
        end
        frame(1'b1, 2);
        frame(1'b1, 2);
        tests++;
        if (layer_ofs !== {10'd3, 10'd2, 10'd1} || obs_vec !== exp_vec()) begin
            fails++; $display("FAIL reset_speeds got %h want 3/2/1", layer_ofs);
        end
    endtask

    task automatic test_random();
        bit rn = 1;
        bit fs;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) == 0) rn = !rn;
            fs = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 799) != 0);
            tick(fs, rn, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            tests++;
            if (obs_vec !== exp_vec() || obs_ready !== !fs) begin
                fails++; $display("FAIL random_c%0d got %h rdy=%b want %h rdy=%b", c, obs_vec, obs_ready, exp_vec(), !fs);
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; frame_start = 1'b0; run = 1'b0; cfg_valid = 1'b0;
        cfg_layer = 2'd0; cfg_speed = 4'd0;
        @(posedge clk); #1;
        test_reset();
        test_fade_in();
        test_speed_wrap();
        test_cfg_hold();
        test_scene_cycle();
        test_run_drop();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
